// File: rtl/stack_alu_seq.sv
// Sequential signed 8-bit ALU: pops two operands from an external stack, computes
// ADD/SUB/MUL/DIV and pushes the result. Define STACK_ALU_DIV_EN to build the divider.
module stack_alu_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] stk_dout,
  input  logic [4:0] stk_count,
  output logic       stk_pop,
  output logic       stk_push,
  output logic [7:0] stk_din,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       carryOut
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] POP1  = 3'd1;
  localparam logic [2:0] POP2  = 3'd2;
  localparam logic [2:0] EXEC  = 3'd3;
  localparam logic [2:0] DIVIT = 3'd4;
  localparam logic [2:0] PUSH  = 3'd5;
  localparam logic [2:0] FIN   = 3'd6;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  logic [2:0]  r_state;
  logic [2:0]  w_state_d;
  logic [1:0]  r_op;
  logic [7:0]  r_in1;
  logic [7:0]  r_in2;
  logic [7:0]  r_result;
  logic        r_err;
  logic        r_carry;

  logic        w_underflow;
  logic        w_full;
  logic        w_op_bad;
  logic [8:0]  w_sum;
  logic [8:0]  w_diff;
  logic [15:0] w_prod;
  logic        w_mul_ovf;
  logic [7:0]  w_alu;
  logic        w_carry;

  assign w_underflow = (stk_count < 5'd2);
  assign w_full      = (stk_count == 5'd16);

  assign w_sum  = {1'b0, r_in1} + {1'b0, r_in2};
  assign w_diff = {1'b0, r_in1} - {1'b0, r_in2};
  assign w_prod = $signed({{8{r_in1[7]}}, r_in1}) * $signed({{8{r_in2[7]}}, r_in2});
  // Signed product fits in 8 bits only when bits 15..7 are all sign copies.
  assign w_mul_ovf = !((&w_prod[15:7]) || (~|w_prod[15:7]));

`ifdef STACK_ALU_DIV_EN
  logic [7:0] r_rem;
  logic [7:0] r_quo;
  logic [2:0] r_cnt;
  logic [7:0] w_mag1;
  logic [7:0] w_mag2;
  logic [8:0] w_shift;
  logic       w_ge;
  logic [7:0] w_rem_d;
  logic [7:0] w_quo_d;
  logic [7:0] w_quo_signed;

  assign w_mag1  = r_in1[7] ? (~r_in1 + 8'd1) : r_in1;
  assign w_mag2  = r_in2[7] ? (~r_in2 + 8'd1) : r_in2;
  // One restoring step: shift next dividend bit in, subtract divisor if it fits.
  assign w_shift = {r_rem, r_quo[7]};
  assign w_ge    = (w_shift >= {1'b0, w_mag2});
  assign w_rem_d = w_ge ? 8'(w_shift - {1'b0, w_mag2}) : w_shift[7:0];
  assign w_quo_d = {r_quo[6:0], w_ge};
  assign w_quo_signed = (r_in1[7] ^ r_in2[7]) ? (~w_quo_d + 8'd1) : w_quo_d;
  assign w_op_bad = 1'b0;
`else
  assign w_op_bad = (r_op == OP_DIV);
`endif

  always_comb begin
    w_alu   = 8'h00;
    w_carry = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_alu   = w_sum[7:0];
        w_carry = w_sum[8];
      end
      OP_SUB: begin
        w_alu   = w_diff[7:0];
        w_carry = w_diff[8];
      end
      OP_MUL: begin
        w_alu   = w_prod[7:0];
        w_carry = w_mul_ovf;
      end
      default: begin
        w_alu   = 8'h00;
        w_carry = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE: if (start) w_state_d = POP1;
      POP1: w_state_d = (w_underflow || w_op_bad) ? FIN : POP2;
      POP2: w_state_d = EXEC;
      EXEC: begin
`ifdef STACK_ALU_DIV_EN
        if (r_op == OP_DIV) w_state_d = (r_in2 == 8'h00) ? FIN : DIVIT;
        else w_state_d = PUSH;
`else
        w_state_d = PUSH;
`endif
      end
`ifdef STACK_ALU_DIV_EN
      DIVIT: if (r_cnt == 3'd7) w_state_d = PUSH;
`else
      DIVIT: w_state_d = IDLE;
`endif
      PUSH:    w_state_d = FIN;
      FIN:     w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_op     <= OP_ADD;
      r_in1    <= 8'h00;
      r_in2    <= 8'h00;
      r_result <= 8'h00;
      r_err    <= 1'b0;
      r_carry  <= 1'b0;
`ifdef STACK_ALU_DIV_EN
      r_rem    <= 8'h00;
      r_quo    <= 8'h00;
      r_cnt    <= 3'd0;
`endif
    end else begin
      r_state <= w_state_d;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op  <= op;
            r_err <= 1'b0;
          end
        end
        POP1: begin
          if (w_underflow || w_op_bad) r_err <= 1'b1;
          else r_in1 <= stk_dout;
        end
        POP2: r_in2 <= stk_dout;
        EXEC: begin
`ifdef STACK_ALU_DIV_EN
          if (r_op == OP_DIV) begin
            if (r_in2 == 8'h00) begin
              r_err <= 1'b1;
            end else begin
              r_rem <= 8'h00;
              r_quo <= w_mag1;
              r_cnt <= 3'd0;
            end
          end else begin
            r_result <= w_alu;
          end
`else
          r_result <= w_alu;
`endif
        end
`ifdef STACK_ALU_DIV_EN
        DIVIT: begin
          r_rem <= w_rem_d;
          r_quo <= w_quo_d;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) r_result <= w_quo_signed;
        end
`endif
        PUSH: begin
          r_carry <= w_carry;
          if (w_full) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset silences them at once.
  assign stk_pop  = ((r_state == POP1) && !w_underflow && !w_op_bad) || (r_state == POP2);
  assign stk_push = (r_state == PUSH) && !w_full;
  assign stk_din  = r_result;
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == FIN);
  assign err      = r_err;
  assign carryOut = r_carry;

  a_pop_push_excl: assert property (@(posedge clk) disable iff (!reset) !(stk_pop && stk_push));
  a_done_pulse:    assert property (@(posedge clk) disable iff (!reset) done |=> !done);

endmodule

// File: tb/tb_stack_alu_seq.sv
// Bench for stack_alu_seq: a 16-deep stack model feeds the DUT; a per-cycle
// expectation queue from a spec-level model is compared on every falling edge.
module tb_stack_alu_seq;

`ifdef STACK_ALU_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] op;
  logic [7:0] stk_dout;
  logic [4:0] stk_count;
  logic       stk_pop;
  logic       stk_push;
  logic [7:0] stk_din;
  logic       busy;
  logic       done;
  logic       err;
  logic       carryOut;

  stack_alu_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .stk_dout  (stk_dout),
    .stk_count (stk_count),
    .stk_pop   (stk_pop),
    .stk_push  (stk_push),
    .stk_din   (stk_din),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .carryOut  (carryOut)
  );

  always #5 clk = ~clk;

  // Stack environment
  logic [7:0] mem [16];
  logic [4:0] sp = 5'd0;
  logic       clr_en = 1'b0;
  logic       ld_en = 1'b0;
  logic [7:0] ld_val = 8'h00;

  assign stk_count = sp;
  assign stk_dout  = (sp != 5'd0) ? mem[4'(sp - 5'd1)] : 8'h00;

  always @(posedge clk) begin
    if (clr_en) sp <= 5'd0;
    else if (ld_en) begin
      mem[sp[3:0]] <= ld_val;
      sp <= sp + 5'd1;
    end else if (stk_pop && sp != 5'd0) sp <= sp - 5'd1;
    else if (stk_push && sp != 5'd16) begin
      mem[sp[3:0]] <= stk_din;
      sp <= sp + 5'd1;
    end
  end

  typedef struct packed {
    logic       pop;
    logic       push;
    logic       busy;
    logic       done;
    logic       err;
    logic       chk_din;
    logic [7:0] din;
    logic       chk_carry;
    logic       carry;
  } cyc_t;

  cyc_t q[$];
  logic idle_err = 1'b0;
  bit   chk_on = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc_t e;
    if (chk_on) begin
      e = '0;
      e.err = idle_err;
      if (q.size() > 0) e = q.pop_front();
      check("pop", {31'd0, stk_pop}, {31'd0, e.pop});
      check("push", {31'd0, stk_push}, {31'd0, e.push});
      check("busy", {31'd0, busy}, {31'd0, e.busy});
      check("done", {31'd0, done}, {31'd0, e.done});
      check("err", {31'd0, err}, {31'd0, e.err});
      if (e.chk_din) check("din", {24'd0, stk_din}, {24'd0, e.din});
      if (e.chk_carry) check("carry", {31'd0, carryOut}, {31'd0, e.carry});
    end
  end

  // Result of an operation from the arithmetic definitions alone.
  function automatic void model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] res, output logic c, output bit dz);
    int sa, sb, p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    res = 8'h00;
    c = 1'b0;
    dz = 1'b0;
    case (o)
      2'b00: begin p = int'(a) + int'(b); res = 8'(p); c = (p > 255); end
      2'b01: begin p = int'(a) - int'(b); res = 8'(p); c = (a < b); end
      2'b10: begin p = sa * sb; res = 8'(p); c = (p > 127) || (p < -128); end
      default: begin
        if (sb == 0) dz = 1'b1;
        else begin p = sa / sb; res = 8'(p); end
      end
    endcase
  endfunction

  task automatic stk_clear();
    clr_en = 1'b1;
    @(posedge clk);
    #1 clr_en = 1'b0;
  endtask

  task automatic stk_load(input logic [7:0] v);
    ld_val = v;
    ld_en = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input bit mid);
    logic [7:0] a, b, res;
    logic c;
    bit dz, pops, pushes, e_err;
    int lat, waited;
    cyc_t e;
    pops = 0; pushes = 0; e_err = 0; res = 8'h00; c = 1'b0; dz = 0;
    if (o == 2'b11 && !DivEn) begin
      lat = 2; e_err = 1;
    end else if (sp < 5'd2) begin
      lat = 2; e_err = 1;
    end else begin
      a = mem[4'(sp - 5'd1)];
      b = mem[4'(sp - 5'd2)];
      model(o, a, b, res, c, dz);
      pops = 1;
      if (dz) begin
        lat = 4; e_err = 1;
      end else begin
        lat = (o == 2'b11) ? 13 : 5;
        pushes = 1;
      end
    end
    @(posedge clk);
    #1 start = 1'b1;
    op = o;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < lat; k++) begin
      e = '0;
      e.busy = 1'b1;
      e.pop = pops && (k < 2);
      e.push = pushes && (k == lat - 2);
      e.chk_din = e.push;
      e.din = res;
      e.done = (k == lat - 1);
      e.err = e_err && (k == lat - 1);
      e.chk_carry = pushes && (k == lat - 1);
      e.carry = c;
      q.push_back(e);
    end
    idle_err = e_err;
    waited = 0;
    if (mid) begin
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      waited = 3;
    end
    repeat (lat + 1 - waited) @(posedge clk);
    #1;
  endtask

  task automatic do_case(input string name, input int n, input logic [7:0] v0,
                         input logic [7:0] v1, input logic [1:0] o, input int exp_sp,
                         input logic [7:0] exp_top, input bit chk_c, input logic exp_c,
                         input bit mid);
    stk_clear();
    stk_load(v0);
    if (n == 2) stk_load(v1);
    run_op(o, mid);
    check({name, "_sp"}, {27'd0, sp}, exp_sp);
    if (exp_sp > 0) check({name, "_top"}, {24'd0, stk_dout}, {24'd0, exp_top});
    if (chk_c) check({name, "_cy"}, {31'd0, carryOut}, {31'd0, exp_c});
    check({name, "_qempty"}, q.size(), 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_pop"}, {31'd0, stk_pop}, 0);
    check({name, "_push"}, {31'd0, stk_push}, 0);
    check({name, "_busy"}, {31'd0, busy}, 0);
    check({name, "_done"}, {31'd0, done}, 0);
    check({name, "_err"}, {31'd0, err}, 0);
    check({name, "_cy"}, {31'd0, carryOut}, 0);
    check({name, "_din"}, {24'd0, stk_din}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op = 2'b00;
    stk_clear();
    @(negedge clk);
    check_all_zero("rst");
    reset = 1'b1;
    chk_on = 1'b1;

    do_case("add_7_2", 2, 8'd7, 8'd2, 2'b00, 1, 8'h09, 1, 1'b0, 0);
    do_case("sub_2_8", 2, 8'd2, 8'd8, 2'b01, 1, 8'h06, 1, 1'b0, 0);
    do_case("sub_6_4", 2, 8'd6, 8'd4, 2'b01, 1, 8'hFE, 1, 1'b1, 0);
    do_case("mul_9_3", 2, 8'd9, 8'd3, 2'b10, 1, 8'h1B, 1, 1'b0, 1);
    do_case("mul_64_4", 2, 8'd64, 8'd4, 2'b10, 1, 8'h00, 1, 1'b1, 0);
    do_case("add_cy", 2, 8'hF0, 8'h20, 2'b00, 1, 8'h10, 1, 1'b1, 0);
    do_case("underflow", 1, 8'd5, 8'd0, 2'b00, 1, 8'h05, 0, 1'b0, 0);
    do_case("add_after_err", 2, 8'h11, 8'h22, 2'b00, 1, 8'h33, 1, 1'b0, 0);
    if (DivEn) begin
      do_case("div_27_54", 2, 8'd27, 8'd54, 2'b11, 1, 8'h02, 1, 1'b0, 0);
      do_case("div_zero", 2, 8'd0, 8'd5, 2'b11, 0, 8'h00, 0, 1'b0, 0);
      do_case("div_m128", 2, 8'hFF, 8'h80, 2'b11, 1, 8'h80, 1, 1'b0, 0);
      do_case("div_neg", 2, 8'd7, 8'hEC, 2'b11, 1, 8'hFE, 1, 1'b0, 0);
    end else begin
      do_case("div_off", 2, 8'd1, 8'd2, 2'b11, 2, 8'h02, 0, 1'b0, 0);
    end

    // Leave carryOut set, then abort an operation mid-flight.
    do_case("sub_pre", 2, 8'd6, 8'd4, 2'b01, 1, 8'hFE, 1, 1'b1, 0);
    chk_on = 1'b0;
    stk_clear();
    stk_load(DivEn ? 8'd27 : 8'd7);
    stk_load(DivEn ? 8'd54 : 8'd2);
    @(posedge clk);
    #1 start = 1'b1;
    op = DivEn ? 2'b11 : 2'b00;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (DivEn ? 5 : 2) @(posedge clk);
    #1 reset = 1'b0;
    #1 check_all_zero("abort");
    repeat (2) begin
      @(negedge clk);
      check("abort_hold_pop", {31'd0, stk_pop}, 0);
      check("abort_hold_push", {31'd0, stk_push}, 0);
    end
    check("abort_sp", {27'd0, sp}, 0);
    @(negedge clk);
    reset = 1'b1;
    idle_err = 1'b0;
    q.delete();
    chk_on = 1'b1;
    do_case("add_fresh", 2, 8'h40, 8'h3F, 2'b00, 1, 8'h7F, 1, 1'b0, 0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_alu_seq.md
STACK_ALU_SEQ -- requirements
Module: stack_alu_seq

Interface
REQ-001 The module SHALL have one clock, clk; reset is asynchronous and active-low, on port reset.
REQ-002 Port list SHALL be exactly:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request one arithmetic operation
- op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
- stk_dout  in  8  current top-of-stack value, combinational from stack
- stk_count  in  5  stack occupancy, 0..16
- stk_pop  out  1  one-cycle pop strobe
- stk_push  out  1  one-cycle push strobe
- stk_din  out  8  value to push
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  operation error flag
- carryOut  out  1  carry/borrow/overflow of the last operation

Function
REQ-003 States SHALL be IDLE, POP1, POP2, EXEC, DIVIT, PUSH and FIN.
REQ-004 In IDLE, start=1 SHALL latch op, clear err, and go to POP1; start while busy SHALL be ignored.
REQ-005 POP1 SHALL check stk_count: if below 2, set err, issue no pop, and go to FIN; otherwise, assert stk_pop, capture stk_dout into in1, and go to POP2.
REQ-006 POP2 SHALL assert stk_pop, capture stk_dout into in2, and go to EXEC.
REQ-007 Operands SHALL be signed 8-bit two's complement: ADD=in1+in2, SUB=in1-in2, MUL=low 8 bits of in1*in2, DIV=in1/in2 truncated toward zero.
REQ-008 For ADD, SUB and MUL, EXEC SHALL compute in one cycle and go to PUSH.
REQ-009 For DIV, EXEC SHALL go to DIVIT, which SHALL perform exactly 8 restoring iterations (one per cycle) on magnitudes, then sign-correct the result and go to PUSH.
REQ-010 DIV with in2=0 SHALL skip DIVIT, set err, skip PUSH, and go to FIN; both operands stay consumed.
REQ-011 PUSH SHALL assert stk_push for one cycle with stk_din=result; if stk_count=16, it SHALL set err and not push.
REQ-012 carryOut SHALL be registered in PUSH:
- ADD: unsigned carry out of bit 7
- SUB: borrow (in1 < in2 unsigned)
- MUL: 1 if the signed product does not fit in 8 bits
- DIV: 0
REQ-013 FIN SHALL pulse done for one cycle and return to IDLE; err SHALL hold until the next accepted start.
REQ-014 Latency from the start sampling edge to done high SHALL be 5 cycles for ADD/SUB/MUL, 13 cycles for DIV, and 2 cycles for the underflow error.
REQ-015 stk_pop and stk_push SHALL never be asserted in the same cycle, and at most two pops and one push SHALL occur per operation.

Reset
REQ-016 While reset=0, the state SHALL be IDLE and stk_pop, stk_push, busy, done, err and carryOut SHALL be 0; stk_din, in1 and in2 SHALL be 0x00.
REQ-017 Reset asserted mid-operation SHALL abort immediately, with no further strobes; operands already popped are lost.
REQ-018 After reset release, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-019 With macro STACK_ALU_DIV_EN defined, DIV SHALL behave per REQ-009/010.
REQ-020 Without STACK_ALU_DIV_EN, the DIVIT logic SHALL be omitted; op=11 SHALL set err, issue no pops or push, and pulse done 2 cycles after start.

Verification
REQ-021 Push 7 then 2 (2 on top), op ADD -> one push of 0x09, carryOut=0, done at cycle 5, stk_count net -1.
REQ-022 Push 2 then 8, op SUB -> push 0x06; push 6 then 4, op SUB -> push 0xFE (-2), carryOut=1.
REQ-023 Push 9 then 3, op MUL -> push 0x1B, carryOut=0; push 64 then 4, op MUL -> push 0x00, carryOut=1.
REQ-024 Push 27 then 54, op DIV -> push 0x02 at cycle 13; push 0 then 5, op DIV -> no push, err=1, stk_count net -2.
REQ-025 stk_count=1, op ADD -> no pop, no push, err=1, done 2 cycles after start.
REQ-026 Reset low during DIVIT -> all outputs 0 in the same cycle, no push; after release, an ADD on fresh operands completes correctly.
